coin_start_sequencer: RTL and testbench
=======================================

# coin_start_sequencer

Converts player start requests (keyboard or joystick) into correctly timed cabinet coin and start pulses for the Galaxian core. It sits between the input-mapping logic and the core's P1/P2 coin/start inputs, replacing the direct `coin = start1 | start2` OR. Pulse widths and gaps are counted in video frames, using VBLANK rising edges as the time base, so the game's frame-polled input routines always see them. Dedicated coin buttons pass straight through.

## Interface
Parameters:
- COIN_FRAMES, 4, frames each coin pulse is held (1..15)
- GAP_FRAMES, 8, frames of idle between pulses and after the start pulse (1..15)
- START_FRAMES, 4, frames the start pulse is held (1..15)

Ports:
- clk_sys  in  1  system clock; all logic single-clock on rising edge
- reset  in  1  synchronous, active-high reset
- vblank  in  1  core VBLANK, synchronous to clk_sys
- req_start1  in  1  player-1 start request (level)
- req_start2  in  1  player-2 start request (level)
- coin1_in  in  1  direct coin-1 button
- coin2_in  in  1  direct coin-2 button
- coin1_out  out  1  to core P1 coin
- coin2_out  out  1  to core P2 coin (= registered coin2_in only)
- start1_out  out  1  to core P1 start
- start2_out  out  1  to core P2 start
- busy  out  1  high whenever state != IDLE

## Operation
- tick = vblank & ~vblank_d, where vblank_d is vblank registered; exactly one cycle per frame.
- Request edges: rq1 = req_start1 & ~req1_d, rq2 = req_start2 & ~req2_d. If both occur in the same cycle, player 1 wins; rq2 is dropped.
- State machine: IDLE, COIN, CGAP, START, COOL. A 4-bit frame counter fcnt is cleared on every state entry and increments on tick.
- IDLE: on an accepted edge, latch player (0 = P1, 1 = P2), set coins_left = player + 1 (P1 needs 1 coin, P2 needs 2), then go to COIN.
- COIN: coin1_seq = 1. On the tick that makes fcnt == COIN_FRAMES, decrement coins_left and go to CGAP.
- CGAP: on the tick that makes fcnt == GAP_FRAMES, go to COIN if coins_left != 0, otherwise START.
- START: start1_seq = (player == 0), start2_seq = (player == 1). On the tick that makes fcnt == START_FRAMES, go to COOL.
- COOL: on the tick that makes fcnt == GAP_FRAMES, serve any pending request (load player/coins_left and go to COIN, clear pending); otherwise go to IDLE.
- Pending: an edge accepted in any non-IDLE state sets pending = 1 and pend_player if pending == 0. Later edges are ignored while pending == 1 (one-deep queue, first request wins).
- Outputs are registered:
  - coin1_out = coin1_seq | coin1_in
  - coin2_out = coin2_in
  - start1_out = start1_seq
  - start2_out = start2_seq
- Reset:
  - state = IDLE, fcnt = 0, coins_left = 0, pending = 0.
  - All outputs 0 and busy = 0 on the cycle after reset is sampled.
  - req1_d/req2_d load the current req levels, so a button held through reset produces no request.
  - vblank_d loads vblank.
  - Reset mid-sequence aborts it immediately and emits no further pulses.

## Timing
- Edge sampled at cycle t moves the state to COIN at t+1; coin1_out = 1 and busy = 1 from t+1.
- Each output follows its state: asserted the cycle after state entry and deasserted the cycle after the state is left. Total latency is one register.
- Duration is in whole frames: COIN lasts from entry until the COIN_FRAMES-th tick after entry, inclusive. Actual width is between COIN_FRAMES-1 frames + 1 cycle and COIN_FRAMES frames, depending on request phase.
- A tick in the same cycle as state entry is not counted (the counter clears on entry).
- coin1_in/coin2_in pass through with a fixed 1-cycle latency in every state, including reset release.
- fcnt never exceeds 15. Parameters outside 1..15 are illegal, checked by an elaboration-time assertion.

## Test plan
Common setup: COIN=2, GAP=3, START=2, vblank high for 2 of every 10 cycles.
- P1 flow: pulse req_start1 once → coin1_out high until the 2nd tick, 3 ticks low, start1_out high for 2 ticks, busy low after 3 more ticks. start2_out stays 0 throughout.
- P2 flow: pulse req_start2 → two separate coin1_out pulses with a 3-tick gap, then start2_out; start1_out stays 0.
- Simultaneous req_start1 and req_start2 edges in one cycle → P1 sequence only, no pending entry. Then: req_start2 edge during START, followed by a req_start1 edge → after COOL, exactly one P2 sequence; the P1 edge is lost.
- Hold req_start1 across reset, then release reset → no coin/start pulse and busy = 0. Assert reset in the middle of CGAP → all outputs 0 the next cycle and the state is IDLE.
- Toggle coin1_in and coin2_in during an active sequence → coin1_out = coin1_seq | coin1_in and coin2_out = coin2_in, each delayed 1 cycle.

Source files
------------

// File: rtl/coin_start_sequencer.sv
// coin_start_sequencer: turns player start requests into frame-timed
// coin/start pulses for the Galaxian core; coin buttons pass through.
module coin_start_sequencer #(
  parameter int unsigned COIN_FRAMES  = 4,
  parameter int unsigned GAP_FRAMES   = 8,
  parameter int unsigned START_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic vblank,
  input  logic req_start1,
  input  logic req_start2,
  input  logic coin1_in,
  input  logic coin2_in,
  output logic coin1_out,
  output logic coin2_out,
  output logic start1_out,
  output logic start2_out,
  output logic busy
);

  if (COIN_FRAMES < 1 || COIN_FRAMES > 15 ||
      GAP_FRAMES < 1 || GAP_FRAMES > 15 ||
      START_FRAMES < 1 || START_FRAMES > 15) begin : g_bad_params
    $error("coin_start_sequencer: frame counts must be 1..15");
  end

  localparam logic [3:0] COIN_N  = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_N   = 4'(GAP_FRAMES);
  localparam logic [3:0] START_N = 4'(START_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_CGAP,
    S_START,
    S_COOL
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [1:0] coins_q, coins_d;
  logic       player_q, player_d;
  logic       pend_q, pend_d;
  logic       pend_player_q, pend_player_d;
  logic       vblank_q;
  logic       req1_q, req2_q;
  logic       coin1_out_q, coin1_out_d;
  logic       coin2_out_q;
  logic       start1_out_q, start1_out_d;
  logic       start2_out_q, start2_out_d;

  logic       tick;
  logic       rq1, rq2, acc;
  logic       acc_player;
  logic [3:0] fcnt_inc;

  // state register, edge-detect history and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fcnt_q        <= '0;
      coins_q       <= '0;
      player_q      <= 1'b0;
      pend_q        <= 1'b0;
      pend_player_q <= 1'b0;
      vblank_q      <= vblank;
      req1_q        <= req_start1;
      req2_q        <= req_start2;
      coin1_out_q   <= 1'b0;
      coin2_out_q   <= 1'b0;
      start1_out_q  <= 1'b0;
      start2_out_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      coins_q       <= coins_d;
      player_q      <= player_d;
      pend_q        <= pend_d;
      pend_player_q <= pend_player_d;
      vblank_q      <= vblank;
      req1_q        <= req_start1;
      req2_q        <= req_start2;
      coin1_out_q   <= coin1_out_d;
      coin2_out_q   <= coin2_in;
      start1_out_q  <= start1_out_d;
      start2_out_q  <= start2_out_d;
    end
  end

  // next-state, frame counter, request queue and output decode
  always_comb begin
    tick       = vblank & ~vblank_q;
    rq1        = req_start1 & ~req1_q;
    rq2        = req_start2 & ~req2_q;
    acc        = rq1 | rq2;
    acc_player = ~rq1;
    fcnt_inc   = (fcnt_q == 4'hf) ? fcnt_q : fcnt_q + 4'd1;

    state_d       = state_q;
    fcnt_d        = tick ? fcnt_inc : fcnt_q;
    coins_d       = coins_q;
    player_d      = player_q;
    pend_d        = pend_q;
    pend_player_d = pend_player_q;

    if (state_q != S_IDLE && acc && !pend_q) begin
      pend_d        = 1'b1;
      pend_player_d = acc_player;
    end

    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          player_d = acc_player;
          coins_d  = acc_player ? 2'd2 : 2'd1;
          state_d  = S_COIN;
        end
      end
      S_COIN: begin
        if (tick && fcnt_inc == COIN_N) begin
          coins_d = coins_q - 2'd1;
          state_d = S_CGAP;
        end
      end
      S_CGAP: begin
        if (tick && fcnt_inc == GAP_N)
          state_d = (coins_q != 2'd0) ? S_COIN : S_START;
      end
      S_START: begin
        if (tick && fcnt_inc == START_N)
          state_d = S_COOL;
      end
      S_COOL: begin
        if (tick && fcnt_inc == GAP_N) begin
          if (pend_q) begin
            player_d = pend_player_q;
            coins_d  = pend_player_q ? 2'd2 : 2'd1;
            pend_d   = 1'b0;
            state_d  = S_COIN;
          end else if (acc) begin
            player_d = acc_player;
            coins_d  = acc_player ? 2'd2 : 2'd1;
            pend_d   = 1'b0;
            state_d  = S_COIN;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      fcnt_d = '0;

    coin1_out_d  = (state_d == S_COIN) | coin1_in;
    start1_out_d = (state_d == S_START) & ~player_d;
    start2_out_d = (state_d == S_START) & player_d;
  end

  assign coin1_out  = coin1_out_q;
  assign coin2_out  = coin2_out_q;
  assign start1_out = start1_out_q;
  assign start2_out = start2_out_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_coin_start_sequencer.sv
// tb_coin_start_sequencer: directed scenarios with a per-cycle
// scoreboard of expected coin/start/busy levels.
module tb_coin_start_sequencer;

  logic clk_sys = 1'b0;
  logic reset, vblank, req_start1, req_start2, coin1_in, coin2_in;
  logic coin1_out, coin2_out, start1_out, start2_out, busy;

  coin_start_sequencer #(
    .COIN_FRAMES(2), .GAP_FRAMES(3), .START_FRAMES(2)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank),
    .req_start1(req_start1), .req_start2(req_start2),
    .coin1_in(coin1_in), .coin2_in(coin2_in),
    .coin1_out(coin1_out), .coin2_out(coin2_out),
    .start1_out(start1_out), .start2_out(start2_out),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int    cyc;
    logic  c1, s1, s2, bsy;
    string tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic c1_p, c2_p;

  // n-th VBLANK rising edge at or after cycle c (vblank high 2 of 10, tick at c%10==0)
  function automatic int nt(input int c, input int n);
    return ((c + 9) / 10) * 10 + 10 * (n - 1);
  endfunction

  task automatic push_range(input int a, input int b, input logic c1,
                            input logic s1, input logic s2,
                            input logic bsy, input string tag);
    for (int i = a; i <= b; i++) begin
      exp_t e;
      e.cyc = i; e.c1 = c1; e.s1 = s1; e.s2 = s2; e.bsy = bsy; e.tag = tag;
      q.push_back(e);
    end
  endtask

  task automatic push_seq(input int s, input logic p, input string tag,
                          output int nxt);
    int c, e;
    c = s;
    for (int k = 0; k <= int'(p); k++) begin
      e = nt(c, 2); push_range(c, e, 1, 0, 0, 1, tag); c = e + 1;
      e = nt(c, 3); push_range(c, e, 0, 0, 0, 1, tag); c = e + 1;
    end
    e = nt(c, 2); push_range(c, e, 0, ~p, p, 1, tag); c = e + 1;
    e = nt(c, 3); push_range(c, e, 0, 0, 0, 1, tag);
    nxt = e + 1;
  endtask

  task automatic step();
    exp_t e;
    logic [4:0] obs, expv;
    c1_p = coin1_in;
    c2_p = coin2_in;
    @(posedge clk_sys);
    #1;
    cyc++;
    vblank = (cyc % 10) < 2;
    if (q.size() != 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      obs  = {coin1_out, coin2_out, start1_out, start2_out, busy};
      expv = {e.c1 | c1_p, c2_p, e.s1, e.s2, e.bsy};
      checks++;
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s cyc=%0d observed c1c2s1s2b=%b expected=%b",
               e.tag, cyc, obs, expv);
      end
    end
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  initial begin
    int n, n2;
    reset = 1'b1; vblank = 1'b1;
    req_start1 = 1'b0; req_start2 = 1'b0;
    coin1_in = 1'b0; coin2_in = 1'b0;

    push_range(1, 3, 0, 0, 0, 0, "rst");
    run_to(3); reset = 1'b0;

    push_range(4, 12, 0, 0, 0, 0, "idle");
    run_to(12); req_start1 = 1'b1;
    push_seq(13, 1'b0, "p1", n);
    push_range(n, 119, 0, 0, 0, 0, "p1_end");
    run_to(13); req_start1 = 1'b0;

    run_to(119); req_start2 = 1'b1;
    push_seq(120, 1'b1, "p2", n);
    push_range(n, 279, 0, 0, 0, 0, "p2_end");
    run_to(120); req_start2 = 1'b0;
    run_to(125); coin1_in = 1'b1;
    run_to(127); coin1_in = 1'b0; coin2_in = 1'b1;
    run_to(145); coin1_in = 1'b1;
    run_to(148); coin1_in = 1'b0; coin2_in = 1'b0;

    run_to(279); req_start1 = 1'b1; req_start2 = 1'b1;
    push_seq(280, 1'b0, "sim", n);
    push_seq(n, 1'b1, "pend", n2);
    push_range(n2, 605, 0, 0, 0, 0, "lost");
    run_to(280); req_start1 = 1'b0; req_start2 = 1'b0;
    run_to(335); req_start2 = 1'b1;
    run_to(336); req_start2 = 1'b0;
    run_to(337); req_start1 = 1'b1;
    run_to(338); req_start1 = 1'b0;

    run_to(605); reset = 1'b1;
    push_range(606, 649, 0, 0, 0, 0, "hold");
    run_to(606); req_start1 = 1'b1;
    run_to(608); reset = 1'b0;
    run_to(640); req_start1 = 1'b0;

    run_to(649); req_start1 = 1'b1;
    push_range(650, 660, 1, 0, 0, 1, "rcg");
    push_range(661, 670, 0, 0, 0, 1, "rcg");
    push_range(671, 700, 0, 0, 0, 0, "rcg_rst");
    run_to(650); req_start1 = 1'b0;
    run_to(670); reset = 1'b1;
    run_to(673); reset = 1'b0;
    run_to(700);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain left=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
